mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares one single-ported RAM between the instruction fetch port and the data port of the pipelined datapath.
// - Data requests have priority. A streak limit stops instruction fetch from being starved.
// - Produces ihit/dhit completion pulses for the pipeline. A watchdog aborts an access when the RAM hangs.
// PARAMETERS
// - MAX_D_STREAK  4   consecutive data grants allowed while iREN is pending; the next grant then goes to instruction
// - TIMEOUT       64  access cycles without ram_ready before abort; 0 disables the watchdog
// - CNT_W         32  width of the performance counters (ARB_PERF_EN only)
// PORTS
// - CLK          in   1      clock, rising edge
// - nRST         in   1      reset, asynchronous, active-low
// - iREN         in   1      instruction read request; held high until ihit
// - iaddr        in   32     instruction address
// - iload        out  32     instruction read data; valid while ihit=1
// - ihit         out  1      instruction access complete (1-cycle pulse)
// - dREN         in   1      data read request; held high until dhit
// - dWEN         in   1      data write request; held high until dhit
// - daddr        in   32     data address
// - dstore       in   32     data write value
// - dload        out  32     data read value; valid while dhit=1
// - dhit         out  1      data access complete (1-cycle pulse)
// - ramREN       out  1      RAM read strobe
// - ramWEN       out  1      RAM write strobe
// - ramaddr      out  32     RAM address
// - ramstore     out  32     RAM write data
// - ramload      in   32     RAM read data; valid with ram_ready
// - ram_ready    in   1      RAM access done this cycle
// - bus_err      out  1      watchdog abort (1-cycle pulse)
// - i_grants, d_grants, busy_cycles  out  CNT_W  perf counters (ARB_PERF_EN only)
// BEHAVIOUR
// - Reset: state=IDLE, streak=0, wd=0. All outputs 0. Asynchronous: RAM strobes drop in the same cycle, even mid-access.
// - States: IDLE, IACC, DACC. Registers: latched addr/store/we, 5-bit streak, watchdog counter wd.
// - IDLE, data request pending (dREN|dWEN):
//   - if iREN & streak==MAX_D_STREAK -> IACC
//   - otherwise -> DACC
// - IDLE, only iREN pending -> IACC. IDLE, no request -> stay.
// - On a grant, latch the requester's address and, for data, dstore and we=dWEN.
// - dREN & dWEN both high: treated as a write.
// - Streak rule on a data grant:
//   - iREN high -> streak increments, saturating at MAX_D_STREAK
//   - iREN low -> streak=0
// - An instruction grant clears streak.
// - IACC/DACC drive RAM from the latched registers only.
//   - IACC: ramREN=1.
//   - DACC: ramWEN=we, ramREN=~we.
//   - Strobes are 0 in IDLE; ramaddr/ramstore hold their last values.
// - Completion:
//   - ihit = (state==IACC) & ram_ready & iREN; iload=ramload (combinational pass-through).
//   - dhit = (state==DACC) & ram_ready & (dREN|dWEN); dload=ramload.
//   - On ram_ready, next state=IDLE.
// - Minimum latency: request seen in IDLE at cycle N; RAM strobe at N+1; hit at N+1 if ram_ready=1. One-cycle turnaround through IDLE between accesses.
// - Requester drops its request mid-access: the RAM access still runs to completion. No hit is produced and the result is discarded.
// - Watchdog:
//   - wd clears on entry to IACC/DACC and increments each ACC cycle without ram_ready.
//   - When wd==TIMEOUT-1 without ram_ready: bus_err=1 for 1 cycle, next state=IDLE, no hit, streak unchanged.
// - ram_ready while in IDLE is ignored.
// - Address and data widths are fixed at 32 bits; no alignment check is made.
// CONFIGURATION
// - Macro ARB_PERF_EN defined:
//   - i_grants/d_grants increment on each grant; busy_cycles increments each cycle in IACC/DACC.
//   - Counters wrap modulo 2^CNT_W and reset to 0 on nRST.
// - Macro ARB_PERF_EN undefined: the counter ports and logic are absent. Arbitration and timing are identical either way.
// TESTING
// - Reset with RAM mid-access (state DACC) -> ramREN=ramWEN=0 immediately; after release, state IDLE with ihit=dhit=bus_err=0.
// - iREN=1 iaddr=0x40; RAM returns 0x8C010004 after 2 cycles -> ramREN high for 2 cycles; ihit pulses once with iload=0x8C010004.
// - iREN and dWEN both high at IDLE, daddr=0x100, dstore=0xDEADBEEF -> DACC first, ramWEN=1 ramaddr=0x100; IACC follows after dhit.
// - dREN held high continuously with iREN high, ram_ready=1 every access -> grant order D,D,D,D,I,D,... (MAX_D_STREAK=4).
// - iREN high, ram_ready held 0 with TIMEOUT=64 -> bus_err pulses in the 64th access cycle; no ihit; state IDLE next cycle; the fetch is regranted.
// - ARB_PERF_EN on: 3 reads + 2 writes, 1-cycle RAM -> i_grants=3, d_grants=2, busy_cycles=5.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and data access; data wins
// unless fetch has waited MAX_D_STREAK data grants. Define ARB_PERF_EN for the grant/busy counters.
module mem_bus_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             iREN,
  input  logic [31:0]      iaddr,
  output logic [31:0]      iload,
  output logic             ihit,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  output logic [31:0]      dload,
  output logic             dhit,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ram_ready,
  output logic             bus_err,
`ifdef ARB_PERF_EN
  output logic [CNT_W-1:0] i_grants,
  output logic [CNT_W-1:0] d_grants,
  output logic [CNT_W-1:0] busy_cycles,
`endif
  output logic [1:0]       state_o
);

  // Handshake: a requester holds iREN or dREN/dWEN high until its hit pulse; the hit
  // is the single-cycle completion and read data is only meaningful while it is high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  if (CNT_W == 0 || MAX_D_STREAK > 31) begin : g_bad_params
    $error("mem_bus_arbiter: CNT_W must be nonzero and MAX_D_STREAK must fit in 5 bits");
  end

  localparam logic [4:0]  STREAK_MAX = 5'(MAX_D_STREAK);
  localparam logic [31:0] WD_LAST    = 32'(TIMEOUT - 1);

  arb_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        we_q, we_d;
  logic [4:0]  streak_q, streak_d;
  logic [31:0] wd_q, wd_d;

  logic d_req;
  logic wd_expired;

  assign d_req      = dREN | dWEN;
  assign wd_expired = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      we_q     <= 1'b0;
      streak_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      we_q     <= we_d;
      streak_q <= streak_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    we_d     = we_q;
    streak_d = streak_q;
    wd_d     = wd_q;
    ihit     = 1'b0;
    dhit     = 1'b0;
    bus_err  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (d_req && !(iREN && streak_q == STREAK_MAX)) begin
          state_d = DACC;
          addr_d  = daddr;
          store_d = dstore;
          we_d    = dWEN;
          // Streak only counts data grants that actually made a fetch wait.
          if (iREN) streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 5'd1;
          else      streak_d = '0;
        end else if (iREN) begin
          state_d  = IACC;
          addr_d   = iaddr;
          streak_d = '0;
        end
      end
      IACC: begin
        ramREN = 1'b1;
        if (ram_ready) begin
          ihit    = iREN;
          state_d = IDLE;
        end else if (wd_expired) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      DACC: begin
        ramWEN = we_q;
        ramREN = ~we_q;
        if (ram_ready) begin
          dhit    = d_req;
          state_d = IDLE;
        end else if (wd_expired) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign iload    = ramload;
  assign dload    = ramload;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign state_o  = state_q;

`ifdef ARB_PERF_EN
  logic i_grant, d_grant, busy;

  assign i_grant = (state_q == IDLE) && (state_d == IACC);
  assign d_grant = (state_q == IDLE) && (state_d == DACC);
  assign busy    = (state_q == IACC) || (state_q == DACC);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      i_grants    <= '0;
      d_grants    <= '0;
      busy_cycles <= '0;
    end else begin
      if (i_grant) i_grants    <= i_grants + 1'b1;
      if (d_grant) d_grants    <= d_grants + 1'b1;
      if (busy)    busy_cycles <= busy_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: behavioural RAM with random latency, golden memory model,
// expected queues per port checked by a negedge monitor, plus directed boundary cases.
module tb_mem_bus_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 64;
  localparam int CW   = 32;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ihit, dhit, ramREN, ramWEN, bus_err;
  logic        ram_ready = 1'b0;
  logic [31:0] iaddr, daddr, dstore, iload, dload, ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  state_o;
`ifdef ARB_PERF_EN
  logic [CW-1:0] i_grants, d_grants, busy_cycles;
`endif

  mem_bus_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .bus_err(bus_err),
`ifdef ARB_PERF_EN
    .i_grants(i_grants), .d_grants(d_grants), .busy_cycles(busy_cycles),
`endif
    .state_o(state_o)
  );

  // ---------------- clock / global timeout ----------------
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memories: device RAM and golden model ----------------
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] gold    [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  // ---------------- RAM responder ----------------
  int lat_min = 0, lat_max = 0;
  bit ram_hang = 1'b0;
  bit in_acc = 1'b0;
  int acc_cnt, acc_lat;

  always begin
    @(posedge CLK);
    #1;
    if (ramREN || ramWEN) begin
      if (!in_acc) begin
        in_acc  = 1'b1;
        acc_cnt = 0;
        acc_lat = $urandom_range(lat_max, lat_min);
      end else begin
        acc_cnt++;
      end
      if (!ram_hang && acc_cnt >= acc_lat) begin
        ram_ready = 1'b1;
        if (ramWEN) ram_mem[ramaddr] = ramstore;
        ramload = ramREN ? ram_rd(ramaddr) : $urandom;
      end else begin
        ram_ready = 1'b0;
        ramload   = $urandom;
      end
    end else begin
      in_acc    = 1'b0;
      ram_ready = 1'b0;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [63:0] i_exp_q [$];   // {addr, data}
  logic [64:0] d_exp_q [$];   // {we, addr, data}
  bit          grant_log [$]; // 1 = data grant, 0 = instruction grant
  bit          prev_strobe = 1'b0;
  int          ren_cycles = 0, ihit_cnt = 0, berr_cnt = 0;
  logic [63:0] ie;
  logic [64:0] de;

  always @(negedge CLK) begin
    if (!nRST) begin
      prev_strobe = 1'b0;
    end else begin
      if ((ramREN || ramWEN) && !prev_strobe) grant_log.push_back(ramaddr >= 32'h100);
      prev_strobe = ramREN || ramWEN;
      if (ramREN)  ren_cycles++;
      if (bus_err) berr_cnt++;
      if (ihit) begin
        ihit_cnt++;
        check("ihit_expected", 32'(i_exp_q.size() != 0), 32'd1);
        if (i_exp_q.size() != 0) begin
          ie = i_exp_q.pop_front();
          check("iload", iload, ie[31:0]);
          check("i_ramaddr", ramaddr, ie[63:32]);
        end
      end
      if (dhit) begin
        check("ihit_with_dhit", 32'(ihit), 32'd0);
        check("dhit_expected", 32'(d_exp_q.size() != 0), 32'd1);
        if (d_exp_q.size() != 0) begin
          de = d_exp_q.pop_front();
          check("d_ramaddr", ramaddr, de[63:32]);
          check("d_ramWEN", 32'(ramWEN), 32'(de[64]));
          check("d_ramREN", 32'(ramREN), 32'(!de[64]));
          if (de[64]) check("d_ramstore", ramstore, de[31:0]);
          else        check("dload", dload, de[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic align();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_ifetch(input logic [31:0] a);
    int c = 0;
    i_exp_q.push_back({a, gold_rd(a)});
    iaddr = a;
    iREN  = 1'b1;
    do begin
      @(negedge CLK);
      c++;
    end while (!ihit && c < 300);
    if (!ihit) check("ihit_timeout", 32'(ihit), 32'd1);
    align();
    iREN = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [31:0] a, input logic [31:0] v);
    int c = 0;
    if (we) begin
      gold[a] = v;
      d_exp_q.push_back({1'b1, a, v});
      dWEN   = 1'b1;
      dREN   = 1'($urandom_range(0, 1));  // both high must still be a write
      dstore = v;
    end else begin
      d_exp_q.push_back({1'b0, a, gold_rd(a)});
      dREN   = 1'b1;
      dWEN   = 1'b0;
      dstore = $urandom;
    end
    daddr = a;
    do begin
      @(negedge CLK);
      c++;
    end while (!dhit && c < 300);
    if (!dhit) check("dhit_timeout", 32'(dhit), 32'd1);
    align();
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int  acc;
  bit  seen_ihit;
  int  hits;

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_hits", {29'd0, ihit, dhit, bus_err}, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);

    // fetch of 0x40 with a two-cycle RAM
    ram_mem[32'h40] = 32'h8C01_0004;
    gold[32'h40]    = 32'h8C01_0004;
    lat_min = 1; lat_max = 1;
    align();
    ren_cycles = 0; ihit_cnt = 0;
    do_ifetch(32'h40);
    repeat (2) @(negedge CLK);
    check("lat_ramREN_cycles", 32'(ren_cycles), 32'd2);
    check("lat_ihit_count", 32'(ihit_cnt), 32'd1);

    // simultaneous fetch and write: data first
    lat_min = 0; lat_max = 0;
    align();
    grant_log.delete();
    fork
      do_ifetch(32'h40);
      do_data(1'b1, 32'h100, 32'hDEAD_BEEF);
    join
    check("simul_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("simul_first_is_data", 32'(grant_log[0]), 32'd1);
      check("simul_second_is_fetch", 32'(grant_log[1]), 32'd0);
    end

    // streak limit with both requesters always pending
    align();
    grant_log.delete();
    fork
      for (int k = 0; k < 2; k++) do_ifetch(32'h4 * 32'(k + 1));
      for (int k = 0; k < 8; k++) do_data(1'b0, 32'h100 + 32'h4 * 32'(k), 32'h0);
    join
    check("streak_grant_count", 32'(grant_log.size()), 32'd10);
    for (int g = 0; g < 10 && g < grant_log.size(); g++)
      check($sformatf("streak_grant_%0d", g), 32'(grant_log[g]), 32'((g % (MAXS + 1)) != MAXS));

    // watchdog abort on a hung RAM
    ram_hang = 1'b1;
    align();
    berr_cnt = 0;
    i_exp_q.push_back({32'h80, gold_rd(32'h80)});
    iaddr = 32'h80; iREN = 1'b1;
    acc = 0; seen_ihit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (ramREN) acc++;
      seen_ihit |= ihit;
      if (bus_err) break;
    end
    check("wd_bus_err_seen", 32'(bus_err), 32'd1);
    check("wd_access_cycles", 32'(acc), 32'(TMO));
    check("wd_no_ihit", 32'(seen_ihit), 32'd0);
    @(negedge CLK);
    check("wd_idle_after", 32'(ramREN), 32'd0);
    check("wd_bus_err_pulse", 32'(bus_err), 32'd0);
    ram_hang = 1'b0;
    @(negedge CLK);
    check("wd_regrant", 32'(ramREN), 32'd1);
    check("wd_regrant_hit", 32'(ihit), 32'd1);
    align();
    iREN = 1'b0;
    check("wd_berr_count", 32'(berr_cnt), 32'd1);

    // requester drops mid-access: access completes, no hit
    lat_min = 3; lat_max = 3;
    align();
    iaddr = 32'h44; iREN = 1'b1;
    acc = 0; hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (ramREN) acc++;
      if (ihit) hits++;
      if (ramREN && iREN) begin
        align();
        iREN = 1'b0;
      end
    end
    check("drop_access_cycles", 32'(acc), 32'd4);
    check("drop_no_ihit", 32'(hits), 32'd0);

    // randomized traffic
    lat_min = 0; lat_max = 3;
    align();
    fork
      for (int k = 0; k < 30; k++) begin
        do_ifetch(32'h4 * 32'($urandom_range(0, 31)));
        repeat ($urandom_range(0, 3)) align();
      end
      for (int k = 0; k < 30; k++) begin
        do_data(1'($urandom_range(0, 1)), 32'h100 + 32'h4 * 32'($urandom_range(0, 7)), $urandom);
        repeat ($urandom_range(0, 3)) align();
      end
    join

    // asynchronous reset in the middle of a data write
    ram_hang = 1'b1;
    align();
    daddr = 32'h104; dstore = 32'h1234_5678; dWEN = 1'b1;
    repeat (3) @(negedge CLK);
    check("mid_rst_in_write", 32'(ramWEN), 32'd1);
    #1 nRST = 1'b0;
    #1;
    check("mid_rst_ramWEN", 32'(ramWEN), 32'd0);
    check("mid_rst_ramREN", 32'(ramREN), 32'd0);
    dWEN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    ram_hang = 1'b0;
    @(negedge CLK);
    check("post_rst_state", 32'(state_o), 32'd0);
    check("post_rst_hits", {29'd0, ihit, dhit, bus_err}, 32'd0);

`ifdef ARB_PERF_EN
    lat_min = 0; lat_max = 0;
    align();
    for (int k = 0; k < 3; k++) do_ifetch(32'h8 * 32'(k));
    for (int k = 0; k < 2; k++) do_data(1'b1, 32'h120 + 32'h4 * 32'(k), $urandom);
    @(negedge CLK);
    check("perf_i_grants", 32'(i_grants), 32'd3);
    check("perf_d_grants", 32'(d_grants), 32'd2);
    check("perf_busy_cycles", 32'(busy_cycles), 32'd5);
`endif

    repeat (3) @(negedge CLK);
    check("i_queue_drained", 32'(i_exp_q.size()), 32'd0);
    check("d_queue_drained", 32'(d_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
